// File: rtl/subpel_hfilter_stream_if.sv
// subpel_hfilter_stream_if: row-in / filtered-row-out handshake bundle for subpel_hfilter_stream
// master drives start/mode/in_row/in_valid/out_ready; slave (the filter) drives everything else
interface subpel_hfilter_stream_if #(
  parameter int BLK_W = 8,
  parameter int BLK_H = 8,
  parameter int BIT_DEPTH = 8,
  parameter int RA_W = $clog2(BLK_H+7)
);
  logic start, mode, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [RA_W-1:0] row_addr, out_row;
  logic [(BLK_W+7)*BIT_DEPTH-1:0] in_row;
  logic [BLK_W*16-1:0] out_a, out_b, out_c;
  modport master (output start, mode, in_row, in_valid, out_ready,
                  input row_addr, in_ready, out_a, out_b, out_c, out_row, out_valid, busy, done);
  modport slave (input start, mode, in_row, in_valid, out_ready,
                 output row_addr, in_ready, out_a, out_b, out_c, out_row, out_valid, busy, done);
endinterface

// File: rtl/subpel_hfilter_stream.sv
// subpel_hfilter_stream: HEVC 8-tap horizontal luma quarter/half/three-quarter filter, row streamed
// ports: clk, rst (async, active-high), bus (slave): start/mode control, row_addr/in_row/in_valid/in_ready
// row input, out_a/out_b/out_c/out_row/out_valid/out_ready filtered output, busy/done status
module subpel_hfilter_stream #(
  parameter int BLK_W = 8,
  parameter int BLK_H = 8,
  parameter int BIT_DEPTH = 8,
  parameter int RA_W = $clog2(BLK_H+7)
) (
  input logic clk,
  input logic rst,
  subpel_hfilter_stream_if.slave bus
);
  localparam int NP = BLK_W+7;
  localparam int AW = BIT_DEPTH+9;
  localparam int LAST = BLK_H+6;
  localparam int MAXV = (1 << BIT_DEPTH)-1;
  localparam logic signed [7:0] CA [8] = '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0};
  localparam logic signed [7:0] CB [8] = '{-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1};
  localparam logic signed [7:0] CC [8] = '{8'sd0, 8'sd1, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1};
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [RA_W-1:0] row_addr_q, row_addr_d, s1_idx_q, out_row_q;
  logic s1_v_q, s2_v_q, mode_q, done_q, done_d;
  logic [NP*BIT_DEPTH-1:0] s1_row_q;
  logic [BLK_W*16-1:0] a_q, b_q, c_q, a_d, b_d, c_d;
  logic signed [AW-1:0] sa, sb, sc, p;
  logic s2_load, s1_load, accept, out_fire;
  function automatic logic [15:0] post(input logic signed [AW-1:0] s, input logic m);
    logic signed [AW-1:0] r, t;
    r = (s + AW'(32)) >>> 6;
    t = s >>> (BIT_DEPTH-8);
    post = m ? t[15:0] : r[AW-1] ? 16'd0 : r > AW'(MAXV) ? 16'(MAXV) : 16'(r[BIT_DEPTH-1:0]);
  endfunction
  // a stage may advance when it is empty or its contents move on this cycle
  assign s2_load = !s2_v_q || bus.out_ready;
  assign s1_load = !s1_v_q || s2_load;
  assign bus.in_ready = (state_q == RUN) && s1_load;
  assign accept = bus.in_valid && bus.in_ready;
  assign out_fire = s2_v_q && bus.out_ready;
  always_comb begin
    state_d = state_q;
    row_addr_d = row_addr_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = RUN;
        row_addr_d = '0;
      end
      RUN: if (accept) begin
        row_addr_d = row_addr_q + 1'b1;
        state_d = (row_addr_q == RA_W'(LAST)) ? DRAIN : RUN;
      end
      DRAIN: if (out_fire && out_row_q == RA_W'(LAST)) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    a_d = '0;
    b_d = '0;
    c_d = '0;
    sa = '0;
    sb = '0;
    sc = '0;
    p = '0;
    for (int j = 0; j < BLK_W; j++) begin
      sa = '0;
      sb = '0;
      sc = '0;
      for (int k = 0; k < 8; k++) begin
        p = signed'(AW'(s1_row_q[(j+k)*BIT_DEPTH +: BIT_DEPTH]));
        sa = sa + p * AW'(CA[k]);
        sb = sb + p * AW'(CB[k]);
        sc = sc + p * AW'(CC[k]);
      end
      a_d[j*16 +: 16] = post(sa, mode_q);
      b_d[j*16 +: 16] = post(sb, mode_q);
      c_d[j*16 +: 16] = post(sc, mode_q);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_addr_q <= '0;
      done_q <= 1'b0;
      mode_q <= 1'b0;
      s1_v_q <= 1'b0;
      s1_row_q <= '0;
      s1_idx_q <= '0;
      s2_v_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      out_row_q <= '0;
    end else begin
      state_q <= state_d;
      row_addr_q <= row_addr_d;
      done_q <= done_d;
      if (state_q == IDLE && bus.start) mode_q <= bus.mode;
      if (s1_load) s1_v_q <= accept;
      if (accept) begin
        s1_row_q <= bus.in_row;
        s1_idx_q <= row_addr_q;
      end
      if (s2_load) s2_v_q <= s1_v_q;
      // bubbles leave the last results in place so stalled outputs never change
      if (s2_load && s1_v_q) begin
        a_q <= a_d;
        b_q <= b_d;
        c_q <= c_d;
        out_row_q <= s1_idx_q;
      end
    end
  end
  assign bus.row_addr = row_addr_q;
  assign bus.out_row = out_row_q;
  assign bus.out_valid = s2_v_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.out_a = a_q;
  assign bus.out_b = b_q;
  assign bus.out_c = c_q;
endmodule

// File: doc/subpel_hfilter_stream.md
# subpel_hfilter_stream

Parametrised, handshaked successor to the fixed 8-wide luma sub-pixel interpolator. For each block it fetches BLK_H+7 reference rows of BLK_W+7 pixels. Each row passes through the HEVC 8-tap luma filters, producing the quarter (a), half (b) and three-quarter (c) sample rows. Results go downstream under valid/ready backpressure. Outputs are either final clipped pixels or signed 16-bit intermediates, so the block sits ahead of the vertical pass in the separable 2-D path.

## Interface
- BLK_W, 8, output samples per row
- BLK_H, 8, output block height; BLK_H+7 rows are processed per block
- BIT_DEPTH, 8, input pixel width (8..12)
- RA_W, $clog2(BLK_H+7), width of row index ports
- clk  in  1  clock
- rst  in  1  reset; asynchronous and active-high
- start  in  1  one-cycle request to process one block; sampled only in IDLE
- mode  in  1  0 = final (round, clip), 1 = intermediate (shift, no clip); latched on start
- row_addr  out  RA_W  index of the next row wanted; equals rows accepted so far
- in_row  in  (BLK_W+7)*BIT_DEPTH  pixel i at [i*BIT_DEPTH +: BIT_DEPTH]
- in_valid  in  1  in_row holds row row_addr
- in_ready  out  1  row accepted on in_valid & in_ready
- out_a, out_b, out_c  out  BLK_W*16 each  sample j at [j*16 +: 16]
- out_row  out  RA_W  row index of the current outputs
- out_valid  out  1  outputs valid
- out_ready  in  1  outputs consumed on out_valid & out_ready
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse after the last output row transfers

## Operation
- Coefficients, tap k applied to pixel j+k for output j:
  - a: -1,4,-10,58,17,-5,1,0
  - b: -1,4,-11,40,40,-11,4,-1
  - c: 0,1,-5,17,58,-10,4,-1
- Accumulator is signed, BIT_DEPTH+9 bits; it cannot overflow.
- Final mode:
  - compute (sum+32)>>>6, clip to [0, 2^BIT_DEPTH-1]
  - zero-extend to 16 bits
- Intermediate mode:
  - compute sum>>>(BIT_DEPTH-8), arithmetic shift
  - truncate to signed 16 bits; no rounding
- State machine:
  - IDLE: in_ready=0. start moves to RUN and clears the row counter.
  - RUN: in_ready per pipeline rule. Acceptance of row BLK_H+6 moves to DRAIN.
  - DRAIN: in_ready=0. Moves to IDLE with done=1 in the cycle after the last output handshake.
- start is ignored while busy.
- Pipeline has two stages: S1 registers in_row plus its index, S2 registers filter results.
  - S2 loads when empty or when out_ready.
  - S1 loads when empty or when S2 loads.
  - in_ready = RUN & (S1 empty | S2 loads).
  - Full throughput of one row per cycle with out_ready held high.
- Deasserting out_ready holds out_* stable; no row is lost or duplicated.
- row_addr increments on each accepted row and saturates at BLK_H+7 in DRAIN.
- out_row increments per output handshake, 0..BLK_H+6.

## Timing
- Reset values:
  - state IDLE; row_addr=0, out_row=0
  - out_valid=0, in_ready=0, busy=0, done=0
  - out_a/b/c=0; both pipeline stages empty
- Reset mid-block aborts immediately. Any partial results are discarded and no done pulse is issued.
- Latency: a row accepted at edge N appears with out_valid=1 after edge N+2, if unstalled.
- busy rises the cycle after start; RUN in_ready can be high in that same cycle.
- done comes one cycle after the final out handshake. busy falls with done; a new start is accepted on the following cycle.
- With no stalls, one block takes BLK_H+7 accept cycles + 2 + 1 for done.
- If in_valid drops in RUN, the pipeline bubbles; valid rows still emerge in order.

## Test plan
- Flat image, all pixels 100, mode 0, out_ready=1 -> 15 output rows, every a/b/c sample = 100; done exactly once, 3 cycles after the last accept.
- Flat 100, mode 1, BIT_DEPTH 8 -> every sample 0x1900.
- Step row: pixels 0..3=0, 4..14=255, mode 0 -> sample 0: a=52, b=128, c=203.
- Clipping, mode 0:
  - pixel 2=255, rest 0 -> a[0]=0
  - pixels 3,4=255, rest 0 -> b[0]=255
  - same rows in mode 1 -> a[0]=0xF60A, b[0]=0x4FB0
- Backpressure: out_ready random 50%, in_valid random -> 15 rows with out_row 0..14 in order, contents match the model, outputs stable while stalled.
- Reset asserted after 6 accepted rows -> all outputs to reset values the same cycle. A new start then yields a full 15-row block with no stale rows and a single done.
